// File: rtl/cmult_rr_scheduler_pkg.sv
// ============================================================================
// Package     : cmult_pkg
// Description : Shared helpers and types for the round-robin complex
//               multiplier scheduler: minimum-one clog2, default widths and
//               the valid/ID tag carried alongside each in-flight product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmult_pkg;

  // ceil(log2(n)) but never below 1, so a 1-bit ID field always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Default configuration widths.
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA1_DEF   = 32;
  localparam int DATA2_DEF   = 8;
  localparam int PW          = DATA1_DEF + DATA2_DEF + 1;
  localparam int IDW         = clog2_min1(NUM_REQ_DEF);

  // Tag ID field is sized for the largest supported requester count (16);
  // the scheduler uses only the low bits it needs.
  localparam int IDW_MAX = 4;

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } cmult_tag_t;

endpackage : cmult_pkg

`default_nettype wire

// File: rtl/cmult_rr_scheduler_result_fifo.sv
// ============================================================================
// Module      : cmult_result_fifo
// Description : Synchronous result FIFO with occupancy count. Head data reads
//               as zero while empty so the scheduler outputs are clean.
// Ports       : i_clk, i_rst_n (sync, active-low), i_push/i_data,
//               i_pop, o_valid/o_data (head), o_count (occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmult_result_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == COUNT_WIDTH'(DEPTH));
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // The credit scheme upstream must make a push into a full FIFO impossible.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_push && w_full));
    end
  end

endmodule : cmult_result_fifo

`default_nettype wire

// File: rtl/cmult_rr_scheduler.sv
// ============================================================================
// Module      : cmult_rr_scheduler
// Description : Shares one pipelined complex multiplier between NUM_REQ
//               requesters with round-robin arbitration. Each accepted
//               operand set is tagged with its requester ID; products are
//               queued in a credit-protected FIFO and returned in order.
// Ports       : sys_clk_i, rst_n_i (sync, active-low)
//               req_valid_i/req_ready_o, req_d1_*/req_d2_*  (packed per req)
//               mult_d1_*/mult_d2_* (operands out), mult_real_i/imag_i (in)
//               res_valid_o/res_ready_i, res_id_o, res_real_o, res_imag_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmult_rr_scheduler
  import cmult_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA1_WIDTH  = 32,
  parameter int DATA2_WIDTH  = 8,
  parameter int MULT_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                    sys_clk_i,
  input  logic                                    rst_n_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ*DATA1_WIDTH-1:0]          req_d1_real_i,
  input  logic [NUM_REQ*DATA1_WIDTH-1:0]          req_d1_imag_i,
  input  logic [NUM_REQ*DATA2_WIDTH-1:0]          req_d2_real_i,
  input  logic [NUM_REQ*DATA2_WIDTH-1:0]          req_d2_imag_i,
  output logic [DATA1_WIDTH-1:0]                  mult_d1_real_o,
  output logic [DATA1_WIDTH-1:0]                  mult_d1_imag_o,
  output logic [DATA2_WIDTH-1:0]                  mult_d2_real_o,
  output logic [DATA2_WIDTH-1:0]                  mult_d2_imag_o,
  input  logic [DATA1_WIDTH+DATA2_WIDTH:0]        mult_real_i,
  input  logic [DATA1_WIDTH+DATA2_WIDTH:0]        mult_imag_i,
  output logic                                    res_valid_o,
  input  logic                                    res_ready_i,
  output logic [clog2_min1(NUM_REQ)-1:0]          res_id_o,
  output logic [DATA1_WIDTH+DATA2_WIDTH:0]        res_real_o,
  output logic [DATA1_WIDTH+DATA2_WIDTH:0]        res_imag_o
);

  localparam int RES_W   = DATA1_WIDTH + DATA2_WIDTH + 1;
  localparam int ID_W    = clog2_min1(NUM_REQ);
  localparam int DL      = MULT_LATENCY + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int FIFO_W  = ID_W + 2 * RES_W;

  // --------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // --------------------------------------------------------------------------
  if (FIFO_DEPTH < MULT_LATENCY + 2) begin : g_depth_check
    $error("cmult_rr_scheduler: FIFO_DEPTH must be >= MULT_LATENCY+2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_check
    $error("cmult_rr_scheduler: NUM_REQ must be in 2..16");
  end

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [ID_W-1:0]        r_rr_ptr;
  logic [DATA1_WIDTH-1:0] r_d1_real;
  logic [DATA1_WIDTH-1:0] r_d1_imag;
  logic [DATA2_WIDTH-1:0] r_d2_real;
  logic [DATA2_WIDTH-1:0] r_d2_imag;
  cmult_tag_t             r_tag [DL];
  logic [CNT_W-1:0]       r_inflight;

  logic [NUM_REQ-1:0]     w_grant;
  logic [ID_W-1:0]        w_grant_idx;
  logic [ID_W-1:0]        w_cand;
  logic                   w_found;
  logic                   w_accept;
  logic                   w_can_issue;
  logic [CNT_W:0]         w_credit_used;
  logic [CNT_W-1:0]       w_fifo_count;
  logic                   w_push;
  logic                   w_pop;
  logic [FIFO_W-1:0]      w_fifo_wdata;
  logic [FIFO_W-1:0]      w_fifo_rdata;
  logic                   w_fifo_valid;
  logic [DATA1_WIDTH-1:0] w_sel_d1_real;
  logic [DATA1_WIDTH-1:0] w_sel_d1_imag;
  logic [DATA2_WIDTH-1:0] w_sel_d2_real;
  logic [DATA2_WIDTH-1:0] w_sel_d2_imag;

  // --------------------------------------------------------------------------
  // Credit: every slot that is queued or still travelling through the
  // multiplier pipeline holds one FIFO entry in reserve.
  // --------------------------------------------------------------------------
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_inflight};
  assign w_can_issue   = (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  // --------------------------------------------------------------------------
  // Round-robin arbiter: search upward from the last winner + 1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_grant     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + off) % NUM_REQ);
      if (!w_found && req_valid_i[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (w_found && w_can_issue) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_accept    = w_found && w_can_issue;
  assign req_ready_o = w_grant;

  // Operand select for the winning requester.
  always_comb begin
    w_sel_d1_real = '0;
    w_sel_d1_imag = '0;
    w_sel_d2_real = '0;
    w_sel_d2_imag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(w_grant_idx) == i) begin
        w_sel_d1_real = req_d1_real_i[i*DATA1_WIDTH +: DATA1_WIDTH];
        w_sel_d1_imag = req_d1_imag_i[i*DATA1_WIDTH +: DATA1_WIDTH];
        w_sel_d2_real = req_d2_real_i[i*DATA2_WIDTH +: DATA2_WIDTH];
        w_sel_d2_imag = req_d2_imag_i[i*DATA2_WIDTH +: DATA2_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Issue register, tag delay line and in-flight counter.
  // Tag stage 0 lines up with the operands on mult_*_o; stage MULT_LATENCY
  // lines up with the product on mult_*_i and drives the FIFO push.
  // --------------------------------------------------------------------------
  assign w_push = r_tag[MULT_LATENCY].valid;

  always_ff @(posedge sys_clk_i) begin
    if (!rst_n_i) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_d1_real  <= '0;
      r_d1_imag  <= '0;
      r_d2_real  <= '0;
      r_d2_imag  <= '0;
      r_inflight <= '0;
      for (int k = 0; k < DL; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_rr_ptr  <= w_grant_idx;
        r_d1_real <= w_sel_d1_real;
        r_d1_imag <= w_sel_d1_imag;
        r_d2_real <= w_sel_d2_real;
        r_d2_imag <= w_sel_d2_imag;
      end
      r_tag[0].valid <= w_accept;
      r_tag[0].id    <= IDW_MAX'(w_grant_idx);
      for (int k = 1; k < DL; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (w_accept && !w_push) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_accept && w_push) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

  // ID bits above ID_W are always zero; collect them so they are consumed.
  if (ID_W < IDW_MAX) begin : g_id_pad
    logic w_unused_id_hi;
    assign w_unused_id_hi = ^r_tag[MULT_LATENCY].id[IDW_MAX-1:ID_W];
  end

  assign mult_d1_real_o = r_d1_real;
  assign mult_d1_imag_o = r_d1_imag;
  assign mult_d2_real_o = r_d2_real;
  assign mult_d2_imag_o = r_d2_imag;

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  assign w_fifo_wdata = {r_tag[MULT_LATENCY].id[ID_W-1:0], mult_real_i, mult_imag_i};
  assign w_pop        = w_fifo_valid && res_ready_i;

  cmult_result_fifo #(
    .WIDTH       (FIFO_W),
    .DEPTH       (FIFO_DEPTH),
    .COUNT_WIDTH (CNT_W)
  ) u_result_fifo (
    .i_clk   (sys_clk_i),
    .i_rst_n (rst_n_i),
    .i_push  (w_push),
    .i_data  (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_rdata),
    .o_count (w_fifo_count)
  );

  assign res_valid_o = w_fifo_valid;
  assign res_id_o    = w_fifo_rdata[FIFO_W-1 -: ID_W];
  assign res_real_o  = w_fifo_rdata[2*RES_W-1 -: RES_W];
  assign res_imag_o  = w_fifo_rdata[RES_W-1:0];

endmodule : cmult_rr_scheduler

`default_nettype wire
